// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - 640x400@70Hz raster timing: position counters, syncs, video qualifier, frame pulse, blink clock
module vga_sync_gen #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 400,
  parameter int V_FP         = 12,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 35,
  parameter int HS_POL       = 0,
  parameter int VS_POL       = 1,
  parameter int FLASH_FRAMES = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pixEn,
  output logic [9:0] pixelCnt,
  output logic [8:0] lineCnt,
  output logic       hsync,
  output logic       vsync,
  output logic       activeVideo,
  output logic       frameStart,
  output logic       flashClk
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Wrap points are compared by equality, so the counters never run past TOTAL-1.
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [8:0]  V_LAST   = 9'(V_TOTAL - 1);

  // Window bounds carry one extra bit because an interval end may equal TOTAL.
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [7:0]  FLASH_LAST = 8'(FLASH_FRAMES - 1);

  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  // Timing that cannot be represented in the fixed-width position ports is rejected at build time.
  if (H_TOTAL > 1024) begin : g_h_total_check
    $error("vga_sync_gen: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > 512) begin : g_v_total_check
    $error("vga_sync_gen: V_TOTAL exceeds 512");
  end
  if (FLASH_FRAMES < 1 || FLASH_FRAMES > 255) begin : g_flash_check
    $error("vga_sync_gen: FLASH_FRAMES outside 1..255");
  end

  logic [7:0] flash_cnt;

  logic       h_wrap;
  logic       v_wrap;
  logic       frame_wrap;
  logic       flash_wrap;
  logic [9:0] pixel_nxt;
  logic [8:0] line_nxt;
  logic       hsync_nxt;
  logic       vsync_nxt;
  logic       active_nxt;

  // Next position and the qualifiers decoded from it, so registered syncs line up with registered counts.
  always_comb begin
    h_wrap     = (pixelCnt == H_LAST);
    v_wrap     = (lineCnt == V_LAST);
    frame_wrap = h_wrap && v_wrap;
    flash_wrap = frame_wrap && (flash_cnt == FLASH_LAST);

    pixel_nxt = h_wrap ? 10'd0 : pixelCnt + 10'd1;
    line_nxt  = lineCnt;
    if (h_wrap) begin
      line_nxt = v_wrap ? 9'd0 : lineCnt + 9'd1;
    end

    hsync_nxt = ~HS_ON;
    if (({1'b0, pixel_nxt} >= HS_START) && ({1'b0, pixel_nxt} < HS_END)) begin
      hsync_nxt = HS_ON;
    end

    // Line-granular: only changes when line_nxt does, i.e. on the pixel wrap.
    vsync_nxt = ~VS_ON;
    if (({1'b0, line_nxt} >= VS_START) && ({1'b0, line_nxt} < VS_END)) begin
      vsync_nxt = VS_ON;
    end

    active_nxt = ({1'b0, pixel_nxt} < H_VIS) && ({1'b0, line_nxt} < V_VIS);
  end

  // Raster state advances on pixel-enable; a stall freezes everything but drops the frame pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pixelCnt    <= 10'd0;
      lineCnt     <= 9'd0;
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      activeVideo <= 1'b1;
      frameStart  <= 1'b0;
      flashClk    <= 1'b0;
      flash_cnt   <= 8'd0;
    end else if (pixEn) begin
      pixelCnt    <= pixel_nxt;
      lineCnt     <= line_nxt;
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      activeVideo <= active_nxt;
      frameStart  <= frame_wrap;
      if (frame_wrap) begin
        flash_cnt <= flash_wrap ? 8'd0 : flash_cnt + 8'd1;
      end
      if (flash_wrap) begin
        flashClk <= ~flashClk;
      end
    end else begin
      frameStart <= 1'b0;
    end
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Upstream timing stage for the character display path.
- Free-running horizontal and vertical counters for 640x400 @ 70 Hz.
- Produces pixelCnt/lineCnt for the character handler, plus hsync/vsync for the connector, an activeVideo qualifier, a frameStart pulse and a frame-derived flashClk for character blinking.
- Runs on the system clock, gated by a pixel-rate enable.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 400, visible lines per frame
V_FP, 12, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 35, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 1, vsync active level (1 = active-high)
FLASH_FRAMES, 16, frames per flashClk half-period (legal range 1..255)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
pixEn  in  1  pixel-rate clock enable; counters advance only when high
pixelCnt  out  10  horizontal position 0..H_TOTAL-1 (H_TOTAL = 800)
lineCnt  out  9  vertical position 0..V_TOTAL-1 (V_TOTAL = 449)
hsync  out  1  horizontal sync at HS_POL level during sync interval
vsync  out  1  vertical sync at VS_POL level during sync interval
activeVideo  out  1  high when pixelCnt < H_ACTIVE and lineCnt < V_ACTIVE
frameStart  out  1  one-clock pulse on entry to position (0,0)
flashClk  out  1  blink square wave, toggles every FLASH_FRAMES frames

Behaviour:
- Clock and reset: reset reset, asynchronous, active-high; clock clock.
- All outputs are registered.
- hsync, vsync and activeVideo are decoded from next-state counter values, so they are aligned with the pixelCnt/lineCnt held in the same cycle. There is zero cycles of skew between position and its qualifiers.
- Reset values are the outputs for position (0,0):
  - pixelCnt = 0, lineCnt = 0
  - hsync = ~HS_POL, vsync = ~VS_POL
  - activeVideo = 1
  - frameStart = 0, flashClk = 0
  - internal flash frame counter = 0
- Counting, on each clock with pixEn = 1:
  - pixelCnt increments.
  - At pixelCnt == H_TOTAL-1, pixelCnt wraps to 0 and lineCnt increments.
  - At lineCnt == V_TOTAL-1 together with pixelCnt wrap, lineCnt wraps to 0.
- pixEn = 0: all counters and outputs hold, except frameStart, which is forced to 0.
  - Stalls of any length are legal, including pixEn held low for a whole frame.
- hsync is at HS_POL level iff H_ACTIVE+H_FP <= pixelCnt < H_ACTIVE+H_FP+H_SYNC (656..751 at defaults).
- vsync is at VS_POL level iff V_ACTIVE+V_FP <= lineCnt < V_ACTIVE+V_FP+V_SYNC (412..413 at defaults).
  - vsync is line-granular: it changes coincident with pixelCnt wrapping to 0.
- frameStart:
  - High for exactly one clock, in the cycle where the counters hold (0,0) immediately after wrapping from (H_TOTAL-1, V_TOTAL-1).
  - Not asserted on reset release.
  - Not re-asserted while stalled at (0,0).
- flashClk:
  - An internal 8-bit frame counter increments on each frame wrap.
  - When the counter reaches FLASH_FRAMES-1 and a wrap occurs, it clears and flashClk toggles in the same cycle as frameStart.
  - FLASH_FRAMES = 1 toggles every frame.
- Widths:
  - H_TOTAL must be <= 1024 and V_TOTAL <= 512; these limits are compile-time checked.
  - The counter compare is equality against the constant TOTAL-1; there is no overflow path.
- Reset mid-frame: asynchronous return to the reset values; counting resumes from (0,0) on the first enabled edge after deassertion.
- Frame period at defaults: 800 x 449 = 359200 enabled cycles.

Test Plan:
1. pixEn tied 1, run 2 lines -> pixelCnt sequence 0..799,0. hsync low for exactly pixelCnt 656..751 and high elsewhere. lineCnt steps 0 to 1 in the same cycle pixelCnt becomes 0.
2. pixEn tied 1, run 2 frames -> frameStart pulses are 359200 cycles apart, each one clock wide at (0,0). vsync high for lines 412..413 (1600 cycles). activeVideo high for 640x400 = 256000 cycles per frame.
3. pixEn toggling 1-0 (50% duty) -> all counts and sync widths double in clock cycles. Hold pixEn low 100 cycles at (799,448), then high 1 cycle -> single frameStart, no pulse during the stall.
4. FLASH_FRAMES = 2, run 5 frames from reset -> flashClk 0 in frames 0-1, 1 in frames 2-3, 0 from frame 4. Each toggle coincides with frameStart.
5. Assert reset at (300,200) for 3 cycles -> outputs immediately (0,0): activeVideo 1, hsync 1, vsync 0, flashClk 0. The first enabled edge after release yields pixelCnt = 1 and no frameStart.
6. HS_POL = 1, VS_POL = 0 -> hsync high only at 656..751, vsync low only on lines 412..413. Reset values hsync = 0, vsync = 1.
